// File: rtl/npc_fetch_gen_if.sv
// -----------------------------------------------------------------------------
// npc_fetch_gen_if
//
// Fetch request bus between the next-PC generator and the I-cache.
//
// Signals:
//   req_valid  generator -> cache  a fetch request is presented
//   req_ready  cache -> generator  the cache accepts the presented request
//   req_pc     generator -> cache  word-aligned fetch address
//   req_mask   generator -> cache  per-slot valid mask inside the fetch block
//   req_epoch  generator -> cache  flush epoch the request belongs to
//
// Modports:
//   master  the request producer (npc_fetch_gen)
//   slave   the request consumer (I-cache)
// -----------------------------------------------------------------------------
interface npc_fetch_gen_if #(
    parameter int Fetch_Num = 4,
    parameter int Epoch_W   = 2
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_pc;
    logic [Fetch_Num-1:0] req_mask;
    logic [Epoch_W-1:0]   req_epoch;

    modport master (
        output req_valid,
        output req_pc,
        output req_mask,
        output req_epoch,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  req_mask,
        input  req_epoch,
        output req_ready
    );

endinterface : npc_fetch_gen_if

// File: rtl/npc_fetch_gen.sv
// -----------------------------------------------------------------------------
// npc_fetch_gen
//
// Front-end next-PC generator. Presents one fetch-block request at a time to
// the I-cache over a valid/ready handshake. Each request carries the current
// PC, a mask of the valid instruction slots from that PC to the end of the
// fetch block, and the flush epoch it was issued under.
//
// Redirect sources:
//   - backend flush: highest priority, takes effect immediately, bumps epoch,
//     drops any buffered predictor redirect and any presented request.
//   - predictor redirect: applied on the cycle a request fires; if nothing
//     fires it is buffered (newest wins) and applied on the next fire.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-low reset
//   flush_valid  backend redirect strobe
//   flush_pc     backend redirect target (bits [1:0] ignored)
//   bp_valid     predictor redirect strobe
//   bp_pc        predictor redirect target (bits [1:0] ignored)
//   stall        front-end stall; holds off new requests but never retracts
//                one already presented
//   req          fetch request bus (master side)
// -----------------------------------------------------------------------------
module npc_fetch_gen #(
    parameter logic [31:0] ResetValue = 32'h8000_0000,
    parameter int          Fetch_Num  = 4,
    parameter int          Epoch_W    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_valid,
    input  logic [31:0]            flush_pc,
    input  logic                   bp_valid,
    input  logic [31:0]            bp_pc,
    input  logic                   stall,
    npc_fetch_gen_if.master        req
);

    // Fetch block geometry: BLK_BYTES bytes per block, B offset bits.
    localparam int          BLK_BYTES = 4 * Fetch_Num;
    localparam int          B         = $clog2(BLK_BYTES);
    localparam logic [31:0] BLK_MASK  = 32'(BLK_BYTES - 1);
    localparam logic [31:0] BLK_INC   = 32'(BLK_BYTES);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clear the two byte-offset bits of a redirect target.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

    // Start of the following fetch block; wraps modulo 2^32.
    function automatic logic [31:0] seq_next(input logic [31:0] addr);
        return (addr & ~BLK_MASK) + BLK_INC;
    endfunction

    // Slot i is valid when it lies at or after the slot the PC points at.
    // Works for Fetch_Num == 1 too: the slot index is then always zero.
    function automatic logic [Fetch_Num-1:0] slot_mask(input logic [31:0] addr);
        logic [31:0]          slot;
        logic [Fetch_Num-1:0] m;
        slot = (addr & BLK_MASK) >> 2;
        m    = '0;
        for (int i = 0; i < Fetch_Num; i++) begin
            m[i] = (32'(i) >= slot);
        end
        return m;
    endfunction

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [Epoch_W-1:0]   epoch_q, epoch_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [31:0]          pend_pc_q, pend_pc_d;
    logic                 presented_q, presented_d;

    logic                 req_valid_c;
    logic                 fire;

    // A presented request stays up regardless of stall; a fresh one is only
    // offered when the front end is not stalled.
    assign req_valid_c = (state_q == RUN) && (presented_q || !stall);
    assign fire        = req_valid_c && req.req_ready;

    assign req.req_valid = req_valid_c;
    assign req.req_pc    = pc_q;
    assign req.req_mask  = slot_mask(pc_q);
    assign req.req_epoch = epoch_q;

    // State register. Reset is asynchronous so that req_valid drops at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= ResetValue;
            epoch_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            presented_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            presented_q  <= presented_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        presented_d  = presented_q;

        unique case (state_q)
            BOOT: begin
                // Nothing is presented in BOOT, but a flush still lands.
                state_d = RUN;
                if (flush_valid) begin
                    pc_d    = word_align(flush_pc);
                    epoch_d = epoch_q + Epoch_W'(1);
                end
            end

            RUN: begin
                if (flush_valid) begin
                    // A request firing this same cycle keeps its old epoch;
                    // everything queued behind it is discarded.
                    pc_d         = word_align(flush_pc);
                    epoch_d      = epoch_q + Epoch_W'(1);
                    pend_valid_d = 1'b0;
                    presented_d  = 1'b0;
                end else begin
                    if (bp_valid && fire) begin
                        pc_d         = word_align(bp_pc);
                        pend_valid_d = 1'b0;
                    end else if (bp_valid) begin
                        // Newest predictor redirect replaces any older one.
                        pend_valid_d = 1'b1;
                        pend_pc_d    = word_align(bp_pc);
                    end else if (fire && pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else if (fire) begin
                        pc_d = seq_next(pc_q);
                    end

                    if (fire) begin
                        presented_d = 1'b0;
                    end else if (req_valid_c) begin
                        presented_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // An unaccepted request must reappear unchanged unless a flush intervenes.
    a_hold_presented: assert property (
        @(posedge clock) disable iff (!reset)
        (req_valid_c && !req.req_ready && !flush_valid)
            |=> (req_valid_c && $stable(pc_q) && $stable(epoch_q))
    );

    // The PC register only ever holds word-aligned addresses.
    a_pc_aligned: assert property (
        @(posedge clock) disable iff (!reset)
        (pc_q[1:0] == 2'b00)
    );

    // Block offset width is used only for documentation of the geometry.
    logic unused_geom;
    assign unused_geom = ^(32'(B));

endmodule : npc_fetch_gen

// File: tb/tb_npc_fetch_gen.sv
module tb_npc_fetch_gen;

    logic        clock;
    logic        reset;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        bp_valid;
    logic [31:0] bp_pc;
    logic        stall;

    int n_cmp;
    int n_bad;

    npc_fetch_gen_if #(.Fetch_Num(4), .Epoch_W(2)) bus ();

    npc_fetch_gen #(
        .ResetValue (32'h8000_0000),
        .Fetch_Num  (4),
        .Epoch_W    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .bp_valid    (bp_valid),
        .bp_pc       (bp_pc),
        .stall       (stall),
        .req         (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle of stimulus plus the outputs expected while it is applied.
    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        bv;
        logic [31:0] bpc;
        logic        st;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [3:0]  emask;
        logic [1:0]  eep;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  mask;
        logic [1:0]  ep;
    } tx_t;

    tx_t sb_q[$];

    vec_t tab1[25];
    vec_t tab2[3];
    vec_t tab3[3];

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                                input logic bv, input logic [31:0] bpc,
                                input logic st, input logic rdy,
                                input logic ev, input logic [31:0] epc,
                                input logic [3:0] emask, input logic [1:0] eep);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.bv = bv; v.bpc = bpc; v.st = st; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.emask = emask; v.eep = eep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, sample, score, advance a cycle.
    task automatic apply(input vec_t v, input string tag, input int idx);
        tx_t t;
        flush_valid   = v.fv;
        flush_pc      = v.fpc;
        bp_valid      = v.bv;
        bp_pc         = v.bpc;
        stall         = v.st;
        bus.req_ready = v.rdy;
        #1;
        chk($sformatf("%s[%0d].valid", tag, idx), 32'(bus.req_valid), 32'(v.ev));
        chk($sformatf("%s[%0d].pc", tag, idx), bus.req_pc, v.epc);
        if (v.ev && v.rdy) begin
            t.pc = v.epc; t.mask = v.emask; t.ep = v.eep;
            sb_q.push_back(t);
        end
        if (bus.req_valid && bus.req_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s[%0d].fire: unexpected fire at pc %h", tag, idx, bus.req_pc);
            end else begin
                t = sb_q.pop_front();
                chk($sformatf("%s[%0d].fire_pc", tag, idx), bus.req_pc, t.pc);
                chk($sformatf("%s[%0d].fire_mask", tag, idx), 32'(bus.req_mask), 32'(t.mask));
                chk($sformatf("%s[%0d].fire_epoch", tag, idx), 32'(bus.req_epoch), 32'(t.ep));
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid"}, 32'(bus.req_valid), 32'd0);
        chk({tag, ".pc"}, bus.req_pc, 32'h8000_0000);
        chk({tag, ".mask"}, 32'(bus.req_mask), 32'hF);
        chk({tag, ".epoch"}, 32'(bus.req_epoch), 32'd0);
    endtask

    // Entered just after a falling edge with the DUT in RUN; leaves with reset
    // released just after a falling edge, so the next edge is the BOOT edge.
    task automatic async_reset(input string tag);
        flush_valid   = 1'b0;
        bp_valid      = 1'b0;
        stall         = 1'b0;
        bus.req_ready = 1'b0;
        #2;
        chk({tag, ".pre_valid"}, 32'(bus.req_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs({tag, ".mid"});
        chk({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk({tag, ".held_valid"}, 32'(bus.req_valid), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        flush_valid = 1'b0; flush_pc = '0;
        bp_valid = 1'b0; bp_pc = '0;
        stall = 1'b0;
        bus.req_ready = 1'b1;

        //               fv fpc            bv bpc            st rdy ev epc            mask  ep
        tab1[0]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  0, 32'h8000_0000, 4'hF, 2'd0);
        tab1[1]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0000, 4'hF, 2'd0);
        tab1[2]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0010, 4'hF, 2'd0);
        tab1[3]  = mk(1, 32'h8000_0009,  0, 32'h0,          0, 1,  1, 32'h8000_0020, 4'hF, 2'd0);
        tab1[4]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0008, 4'hC, 2'd1);
        tab1[5]  = mk(0, 32'h0,          0, 32'h0,          0, 0,  1, 32'h8000_0010, 4'hF, 2'd1);
        tab1[6]  = mk(0, 32'h0,          1, 32'h8000_0100,  0, 0,  1, 32'h8000_0010, 4'hF, 2'd1);
        tab1[7]  = mk(0, 32'h0,          1, 32'h8000_0200,  0, 0,  1, 32'h8000_0010, 4'hF, 2'd1);
        tab1[8]  = mk(0, 32'h0,          0, 32'h0,          1, 0,  1, 32'h8000_0010, 4'hF, 2'd1);
        tab1[9]  = mk(0, 32'h0,          0, 32'h0,          1, 1,  1, 32'h8000_0010, 4'hF, 2'd1);
        tab1[10] = mk(0, 32'h0,          0, 32'h0,          1, 1,  0, 32'h8000_0200, 4'hF, 2'd1);
        tab1[11] = mk(0, 32'h0,          0, 32'h0,          0, 0,  1, 32'h8000_0200, 4'hF, 2'd1);
        tab1[12] = mk(0, 32'h0,          1, 32'h8000_0300,  0, 0,  1, 32'h8000_0200, 4'hF, 2'd1);
        tab1[13] = mk(1, 32'h8000_1000,  1, 32'h8000_2000,  0, 0,  1, 32'h8000_0200, 4'hF, 2'd1);
        tab1[14] = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_1000, 4'hF, 2'd2);
        tab1[15] = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_1010, 4'hF, 2'd2);
        tab1[16] = mk(1, 32'hFFFF_FFF0,  0, 32'h0,          0, 0,  1, 32'h8000_1020, 4'hF, 2'd2);
        tab1[17] = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'hFFFF_FFF0, 4'hF, 2'd3);
        tab1[18] = mk(1, 32'h0000_0004,  0, 32'h0,          0, 1,  1, 32'h0000_0000, 4'hF, 2'd3);
        tab1[19] = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h0000_0004, 4'hE, 2'd0);
        tab1[20] = mk(0, 32'h0,          1, 32'h0000_0040,  0, 1,  1, 32'h0000_0010, 4'hF, 2'd0);
        tab1[21] = mk(1, 32'h0000_000E,  0, 32'h0,          0, 1,  1, 32'h0000_0040, 4'hF, 2'd0);
        tab1[22] = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h0000_000C, 4'h8, 2'd1);
        tab1[23] = mk(0, 32'h0,          0, 32'h0,          1, 0,  0, 32'h0000_0010, 4'hF, 2'd1);
        tab1[24] = mk(0, 32'h0,          1, 32'h8000_0500,  0, 0,  1, 32'h0000_0010, 4'hF, 2'd1);

        // After a mid-operation reset: the buffered redirect must be gone.
        tab2[0]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  0, 32'h8000_0000, 4'hF, 2'd0);
        tab2[1]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0000, 4'hF, 2'd0);
        tab2[2]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0010, 4'hF, 2'd0);

        // Flush on the BOOT edge.
        tab3[0]  = mk(1, 32'h8000_0044,  0, 32'h0,          0, 1,  0, 32'h8000_0000, 4'hF, 2'd0);
        tab3[1]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0044, 4'hE, 2'd1);
        tab3[2]  = mk(0, 32'h0,          0, 32'h0,          0, 1,  1, 32'h8000_0050, 4'hF, 2'd1);

        @(negedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) apply(tab1[i], "main", i);

        async_reset("rst1");
        for (int i = 0; i < 3; i++) apply(tab2[i], "post_rst", i);

        async_reset("rst2");
        for (int i = 0; i < 3; i++) apply(tab3[i], "boot_flush", i);

        chk("final.sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_npc_fetch_gen
